// File: rtl/edge_detect_multi.sv
// ============================================================================
// edge_detect_multi
// ----------------------------------------------------------------------------
// Multi-channel, mode-selectable edge detector with a glitch filter. Each
// channel runs an independent 4-state Moore FSM (LOW, RISE_PEND, HIGH,
// FALL_PEND). The raw input has to disagree with the accepted level for FILT
// consecutive samples before the level changes. A level change that the
// channel's mode enables is a qualified edge. A qualified edge produces a
// registered 1-cycle pulse and sets a sticky flag. It can also bump a
// saturating counter.
//
// Parameters
//   N_CH   number of independent channels (>= 1)
//   FILT   consecutive differing samples needed to change level (>= 1)
//   CNT_W  width of the per-channel edge counter
//
// Ports
//   clk       in   1           clock; all logic on the rising edge
//   RESET     in   1           synchronous reset, active-high
//   din       in   N_CH        raw channel inputs, synchronous to clk
//   mode      in   2*N_CH      per ch [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   evt_clr   in   N_CH        per-channel flag/counter clear strobe
//   pe        out  N_CH        registered 1-cycle qualified-edge pulse
//   level     out  N_CH        filtered (accepted) level
//   evt_flag  out  N_CH        sticky "qualified edge seen"
//   edge_cnt  out  CNT_W*N_CH  per ch [CNT_W*(i+1)-1:CNT_W*i] saturating count
//
// Configuration
//   EDGE_CNT_EN  defined: per-channel saturating edge counters are built.
//                undefined: no counter logic; edge_cnt is tied to zero.
// ============================================================================
module edge_detect_multi #(
    parameter int N_CH  = 4,
    parameter int FILT  = 1,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic [N_CH-1:0]         din,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [N_CH-1:0]         evt_clr,
    output logic [N_CH-1:0]         pe,
    output logic [N_CH-1:0]         level,
    output logic [N_CH-1:0]         evt_flag,
    output logic [CNT_W*N_CH-1:0]   edge_cnt
);

    // The filter counter only has to reach FILT.
    localparam int FCW = (FILT > 1) ? $clog2(FILT + 1) : 1;
    localparam logic [FCW-1:0] FILT_C = FCW'(FILT);
    localparam logic [FCW-1:0] ONE_C  = FCW'(1);
    localparam logic [FCW-1:0] ZERO_C = FCW'(0);

    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_RISE_PEND = 2'b01,
        ST_HIGH      = 2'b10,
        ST_FALL_PEND = 2'b11
    } state_t;

    state_t          state_r     [N_CH];
    state_t          state_nxt_s [N_CH];
    logic [FCW-1:0]  fcnt_r      [N_CH];
    logic [FCW-1:0]  fcnt_nxt_s  [N_CH];
    logic [FCW-1:0]  fcnt_inc_s  [N_CH];
    logic [N_CH-1:0] rise_s;
    logic [N_CH-1:0] fall_s;
    logic [N_CH-1:0] qual_s;
    logic [N_CH-1:0] level_nxt_s;
    logic [N_CH-1:0] level_r;
    logic [N_CH-1:0] pe_r;
    logic [N_CH-1:0] flag_r;

    // Next-state, filter count and edge qualification for every channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_nxt_s[i] = state_r[i];
            fcnt_nxt_s[i]  = fcnt_r[i];
            fcnt_inc_s[i]  = ZERO_C;
            rise_s[i]      = 1'b0;
            fall_s[i]      = 1'b0;

            case (state_r[i])
                ST_LOW, ST_RISE_PEND: begin
                    if (din[i]) begin
                        // The first differing sample counts as one.
                        if (state_r[i] == ST_LOW) begin
                            fcnt_inc_s[i] = ONE_C;
                        end else begin
                            fcnt_inc_s[i] = fcnt_r[i] + ONE_C;
                        end
                        if (fcnt_inc_s[i] == FILT_C) begin
                            state_nxt_s[i] = ST_HIGH;
                            fcnt_nxt_s[i]  = ZERO_C;
                            rise_s[i]      = 1'b1;
                        end else begin
                            state_nxt_s[i] = ST_RISE_PEND;
                            fcnt_nxt_s[i]  = fcnt_inc_s[i];
                        end
                    end else begin
                        state_nxt_s[i] = ST_LOW;
                        fcnt_nxt_s[i]  = ZERO_C;
                    end
                end
                ST_HIGH, ST_FALL_PEND: begin
                    if (!din[i]) begin
                        if (state_r[i] == ST_HIGH) begin
                            fcnt_inc_s[i] = ONE_C;
                        end else begin
                            fcnt_inc_s[i] = fcnt_r[i] + ONE_C;
                        end
                        if (fcnt_inc_s[i] == FILT_C) begin
                            state_nxt_s[i] = ST_LOW;
                            fcnt_nxt_s[i]  = ZERO_C;
                            fall_s[i]      = 1'b1;
                        end else begin
                            state_nxt_s[i] = ST_FALL_PEND;
                            fcnt_nxt_s[i]  = fcnt_inc_s[i];
                        end
                    end else begin
                        state_nxt_s[i] = ST_HIGH;
                        fcnt_nxt_s[i]  = ZERO_C;
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_LOW;
                    fcnt_nxt_s[i]  = ZERO_C;
                end
            endcase

            level_nxt_s[i] = (state_nxt_s[i] == ST_HIGH) ||
                             (state_nxt_s[i] == ST_FALL_PEND);
            // Mode is sampled at the same edge as the transition.
            qual_s[i] = (rise_s[i] & mode[2*i]) | (fall_s[i] & mode[2*i+1]);
        end
    end

    // FSM state, filter counts, level, pulse and sticky flag registers.
    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= ST_LOW;
                fcnt_r[i]  <= ZERO_C;
            end
            level_r <= {N_CH{1'b0}};
            pe_r    <= {N_CH{1'b0}};
            flag_r  <= {N_CH{1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_r[i] <= state_nxt_s[i];
                fcnt_r[i]  <= fcnt_nxt_s[i];
                // A new edge wins over a clear that arrives in the same cycle.
                if (qual_s[i]) begin
                    flag_r[i] <= 1'b1;
                end else if (evt_clr[i]) begin
                    flag_r[i] <= 1'b0;
                end else begin
                    flag_r[i] <= flag_r[i];
                end
            end
            level_r <= level_nxt_s;
            pe_r    <= qual_s;
        end
    end

    assign pe       = pe_r;
    assign level    = level_r;
    assign evt_flag = flag_r;

`ifdef EDGE_CNT_EN
    logic [CNT_W-1:0] cnt_r [N_CH];

    // Saturating per-channel edge counters; edge plus clear restarts at one.
    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (qual_s[i] && evt_clr[i]) begin
                    cnt_r[i] <= CNT_W'(1);
                end else if (evt_clr[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (qual_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
        assign edge_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
    end
`else
    assign edge_cnt = {(CNT_W*N_CH){1'b0}};
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// ============================================================================
// tb_edge_detect_multi
// ----------------------------------------------------------------------------
// Two instances share one set of inputs: one with FILT=1 and one with FILT=3,
// both with CNT_W=2. A behavioural model tracks each channel's accepted level
// as a run length of disagreeing samples. Every cycle it predicts pe, level,
// evt_flag and edge_cnt. Directed scenarios come first, then random stimulus.
// ============================================================================
module tb_edge_detect_multi;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 2;
    localparam int FILT_A = 1;
    localparam int FILT_B = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       din;
    logic [2*N_CH-1:0]     mode;
    logic [N_CH-1:0]       evt_clr;
    logic [N_CH-1:0]       pe_a, level_a, flag_a;
    logic [N_CH-1:0]       pe_b, level_b, flag_b;
    logic [CNT_W*N_CH-1:0] cnt_a, cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state, index 0 = FILT_A instance, 1 = FILT_B instance.
    int m_lvl  [2][N_CH];
    int m_run  [2][N_CH];
    int m_pe   [2][N_CH];
    int m_flag [2][N_CH];
    int m_cnt  [2][N_CH];

    edge_detect_multi #(.N_CH(N_CH), .FILT(FILT_A), .CNT_W(CNT_W)) u_dut_a (
        .clk(clk), .RESET(rst), .din(din), .mode(mode), .evt_clr(evt_clr),
        .pe(pe_a), .level(level_a), .evt_flag(flag_a), .edge_cnt(cnt_a)
    );

    edge_detect_multi #(.N_CH(N_CH), .FILT(FILT_B), .CNT_W(CNT_W)) u_dut_b (
        .clk(clk), .RESET(rst), .din(din), .mode(mode), .evt_clr(evt_clr),
        .pe(pe_b), .level(level_b), .evt_flag(flag_b), .edge_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int f;
        int edge_seen;
        int qual;
        for (int d = 0; d < 2; d++) begin
            f = (d == 0) ? FILT_A : FILT_B;
            for (int c = 0; c < N_CH; c++) begin
                if (rst) begin
                    m_lvl[d][c] = 0; m_run[d][c] = 0; m_pe[d][c] = 0;
                    m_flag[d][c] = 0; m_cnt[d][c] = 0;
                end else begin
                    edge_seen = 0;
                    if (int'(din[c]) != m_lvl[d][c]) begin
                        m_run[d][c]++;
                        if (m_run[d][c] >= f) begin
                            m_lvl[d][c] = 1 - m_lvl[d][c];
                            m_run[d][c] = 0;
                            edge_seen = 1;
                        end
                    end else begin
                        m_run[d][c] = 0;
                    end
                    if (edge_seen == 0)
                        qual = 0;
                    else if (m_lvl[d][c] == 1)
                        qual = int'(mode[2*c]);
                    else
                        qual = int'(mode[2*c+1]);
                    m_pe[d][c] = qual;
                    if (qual != 0) m_flag[d][c] = 1;
                    else if (evt_clr[c]) m_flag[d][c] = 0;
                    if (qual != 0 && evt_clr[c]) m_cnt[d][c] = 1;
                    else if (evt_clr[c]) m_cnt[d][c] = 0;
                    else if (qual != 0 && m_cnt[d][c] < CMAX) m_cnt[d][c]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [N_CH-1:0]       e_pe, e_lvl, e_flag;
        logic [CNT_W*N_CH-1:0] e_cnt;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N_CH; c++) begin
                e_pe[c]   = (m_pe[d][c] != 0);
                e_lvl[c]  = (m_lvl[d][c] != 0);
                e_flag[c] = (m_flag[d][c] != 0);
`ifdef EDGE_CNT_EN
                e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[d][c]);
`else
                e_cnt[c*CNT_W +: CNT_W] = {CNT_W{1'b0}};
`endif
            end
            if (d == 0) begin
                check_val("pe_f1",    32'(pe_a),    32'(e_pe));
                check_val("level_f1", 32'(level_a), 32'(e_lvl));
                check_val("flag_f1",  32'(flag_a),  32'(e_flag));
                check_val("cnt_f1",   32'(cnt_a),   32'(e_cnt));
            end else begin
                check_val("pe_f3",    32'(pe_b),    32'(e_pe));
                check_val("level_f3", 32'(level_b), 32'(e_lvl));
                check_val("flag_f3",  32'(flag_b),  32'(e_flag));
                check_val("cnt_f3",   32'(cnt_b),   32'(e_cnt));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; din = 4'h0; evt_clr = 4'h0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        int exp_pulses [4];
        logic [N_CH-1:0] mask;
        exp_pulses[0] = 0; exp_pulses[1] = 1; exp_pulses[2] = 1; exp_pulses[3] = 2;

        // T1: reset held with din all ones, then release.
        rst = 1'b1; din = 4'hF; mode = 8'h55; evt_clr = 4'h0;
        tick();
        tick();
        check_val("t1_rst_pe",    32'(pe_a),    32'h0);
        check_val("t1_rst_level", 32'(level_a), 32'h0);
        check_val("t1_rst_flag",  32'(flag_a),  32'h0);
        check_val("t1_rst_cnt",   32'(cnt_a),   32'h0);
        rst = 1'b0;
        tick();
        check_val("t1_level", 32'(level_a), 32'hF);
        check_val("t1_pe",    32'(pe_a),    32'hF);
        tick();
        check_val("t1_pe_drop", 32'(pe_a), 32'h0);

        // T2: rise latency on channel 0.
        do_reset();
        tick();
        din = 4'h1;
        tick();
        check_val("t2_pe_hi", 32'(pe_a), 32'h1);
        tick();
        check_val("t2_pe_lo", 32'(pe_a), 32'h0);

        // T3: glitch filter on the FILT=3 instance, channel 1.
        do_reset();
        din = 4'h2;
        tick();
        tick();
        din = 4'h0;
        tick();
        tick();
        check_val("t3_glitch_level", 32'(level_b[1]), 32'h0);
        check_val("t3_glitch_pe",    32'(pe_b[1]),    32'h0);
        din = 4'h2;
        tick();
        tick();
        check_val("t3_pe_early", 32'(pe_b[1]), 32'h0);
        tick();
        check_val("t3_pe",    32'(pe_b[1]),    32'h1);
        check_val("t3_level", 32'(level_b[1]), 32'h1);

        // T4: a 4-cycle pulse on channel 2 under each mode.
        for (int m = 0; m < 4; m++) begin
            do_reset();
            mode = 8'(m << 4);
            pulses = 0;
            din = 4'h4;
            for (int k = 0; k < 4; k++) begin
                tick();
                pulses += int'(pe_a[2]);
            end
            din = 4'h0;
            for (int k = 0; k < 4; k++) begin
                tick();
                pulses += int'(pe_a[2]);
            end
            check_val($sformatf("t4_pulses_m%0d", m), 32'(pulses), 32'(exp_pulses[m]));
        end

        // T5: sticky flag, set beats clear in the same cycle.
        do_reset();
        mode = 8'h40;
        din = 4'h8; evt_clr = 4'h8;
        tick();
        evt_clr = 4'h0;
        check_val("t5_set_wins", 32'(flag_a[3]), 32'h1);
        tick();
        evt_clr = 4'h8;
        tick();
        evt_clr = 4'h0;
        check_val("t5_clear", 32'(flag_a[3]), 32'h0);

        // T6: five qualified edges on channel 0 saturate a 2-bit counter.
        do_reset();
        mode = 8'h03;
        for (int k = 0; k < 5; k++) begin
            din = din ^ 4'h1;
            tick();
        end
`ifdef EDGE_CNT_EN
        check_val("t6_sat", 32'(cnt_a[1:0]), 32'h3);
`else
        check_val("t6_sat", 32'(cnt_a[1:0]), 32'h0);
`endif
        evt_clr = 4'h1;
        tick();
        evt_clr = 4'h0;
        check_val("t6_clr", 32'(cnt_a[1:0]), 32'h0);

        // Random stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            rst     = ($urandom_range(0, 99) == 0);
            mask    = N_CH'($urandom & $urandom);
            din     = din ^ mask;
            evt_clr = N_CH'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
